// File: rtl/imsic_regfile.sv
// IMSIC interrupt-file register state: indirect CSR read/write/claim from the core
// and MSI sets from the bus. Read data, exception, xtopei and irq are all registered.
module imsic_regfile #(
   parameter int NR_SRC      = 64,
   parameter int NR_VS_FILES = 1,
   parameter int NR_FILES    = 2 + NR_VS_FILES,
   parameter int SRC_W       = $clog2(NR_SRC),
   parameter int VS_W        = $clog2(NR_VS_FILES + 1)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [1:0]                  imsic_priv_lvl_i,
   input  logic [VS_W:0]               imsic_vgein_i,
   input  logic [63:0]                 imsic_addr_i,
   input  logic [63:0]                 imsic_data_i,
   input  logic                        imsic_we_i,
   input  logic                        imsic_claim_i,
   output logic [63:0]                 imsic_data_o,
   output logic                        imsic_exception_o,
   output logic [NR_FILES*SRC_W-1:0]   imsic_xtopei_o,
   input  logic                        msi_valid_i,
   output logic                        msi_ready_o,
   input  logic [$clog2(NR_FILES)-1:0] msi_file_i,
   input  logic [SRC_W-1:0]            msi_id_i,
   output logic [NR_FILES-1:0]         irq_o
);
   localparam int NWORDS = NR_SRC / 64;
   localparam int FW     = $clog2(NR_FILES);

   logic [NR_FILES-1:0]                 deliv_q, deliv_d, irq_q, irq_d;
   logic [NR_FILES-1:0][SRC_W-1:0]      thr_q, thr_d, topei_q, topei_d;
   logic [NR_FILES-1:0][NR_SRC-1:0]     eip_q, eip_d, eie_q, eie_d;
   logic [63:0]                         data_q, data_d;
   logic                                exc_q, exc_d, ready_q, ready_d;

   logic          file_ok, sel_deliv, sel_thr, sel_eip, sel_eie, acc_ok;
   logic [FW-1:0] file;
   logic [4:0]    word;

   always_comb begin
      file_ok = 1'b0;
      file    = '0;
      if (imsic_priv_lvl_i == 2'b11) begin
         file_ok = 1'b1;
      end else if (imsic_priv_lvl_i == 2'b01 && int'(imsic_vgein_i) <= NR_VS_FILES) begin
         file_ok = 1'b1;
         file    = FW'(int'(imsic_vgein_i) + 1);
      end
      // eip words live at 0x80+2k, eie words at 0xC0+2k; odd addresses are holes
      word      = imsic_addr_i[5:1];
      sel_deliv = imsic_addr_i == 64'h70;
      sel_thr   = imsic_addr_i == 64'h72;
      sel_eip   = imsic_addr_i[63:6] == 58'h2 && !imsic_addr_i[0] && int'(word) < NWORDS;
      sel_eie   = imsic_addr_i[63:6] == 58'h3 && !imsic_addr_i[0] && int'(word) < NWORDS;
      acc_ok    = file_ok && (sel_deliv || sel_thr || sel_eip || sel_eie);
   end

   // Update order per edge: CSR write, then claim clear, then MSI set (MSI wins).
   always_comb begin
      deliv_d = deliv_q;
      thr_d   = thr_q;
      eip_d   = eip_q;
      eie_d   = eie_q;
      data_d  = '0;
      exc_d   = !acc_ok;
      ready_d = 1'b1;
      if (acc_ok) begin
         if (sel_deliv)    data_d = {63'b0, deliv_q[file]};
         else if (sel_thr) data_d = {{(64-SRC_W){1'b0}}, thr_q[file]};
         else if (sel_eip) data_d = eip_q[file][64*int'(word) +: 64];
         else              data_d = eie_q[file][64*int'(word) +: 64];
         if (imsic_we_i) begin
            if (sel_deliv)    deliv_d[file] = imsic_data_i[0];
            else if (sel_thr) thr_d[file] = imsic_data_i[SRC_W-1:0];
            else if (sel_eip) eip_d[file][64*int'(word) +: 64] = imsic_data_i;
            else              eie_d[file][64*int'(word) +: 64] = imsic_data_i;
         end
         if (imsic_claim_i && topei_q[file] != '0)
            eip_d[file][topei_q[file]] = 1'b0;
      end
      for (int f = 0; f < NR_FILES; f++) begin
         eip_d[f][0] = 1'b0;
         eie_d[f][0] = 1'b0;
      end
      if (msi_valid_i && ready_q && int'(msi_file_i) < NR_FILES && msi_id_i != '0)
         eip_d[msi_file_i][msi_id_i] = 1'b1;
   end

   // xtopei/irq are computed from next state so they settle on the same edge as the state.
   always_comb begin
      topei_d = '0;
      irq_d   = '0;
      for (int f = 0; f < NR_FILES; f++) begin
         for (int i = NR_SRC - 1; i > 0; i--) begin
            if (eip_d[f][i] && eie_d[f][i] && (thr_d[f] == '0 || i < int'(thr_d[f])))
               topei_d[f] = SRC_W'(i);
         end
         irq_d[f] = deliv_d[f] && topei_d[f] != '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         deliv_q <= '0;
         thr_q   <= '0;
         eip_q   <= '0;
         eie_q   <= '0;
         topei_q <= '0;
         irq_q   <= '0;
         data_q  <= '0;
         exc_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         deliv_q <= deliv_d;
         thr_q   <= thr_d;
         eip_q   <= eip_d;
         eie_q   <= eie_d;
         topei_q <= topei_d;
         irq_q   <= irq_d;
         data_q  <= data_d;
         exc_q   <= exc_d;
         ready_q <= ready_d;
      end
   end

   assign imsic_data_o      = data_q;
   assign imsic_exception_o = exc_q;
   assign imsic_xtopei_o    = topei_q;
   assign irq_o             = irq_q;
   assign msi_ready_o       = ready_q;

endmodule

// File: tb/tb_imsic_regfile.sv
// Scoreboarded bench for imsic_regfile: each access pushes its expected {exception, data}
// and the calling test pops and compares it one cycle later.
module tb_imsic_regfile;
   localparam int NR_SRC = 64, NR_VS_FILES = 1, NR_FILES = 3, SRC_W = 6, VS_W = 1;
   localparam logic [1:0] PM = 2'b11, PS = 2'b01;

   logic                      clk_i = 1'b0, rst_ni = 1'b0;
   logic [1:0]                imsic_priv_lvl_i = '0;
   logic [VS_W:0]             imsic_vgein_i = '0;
   logic [63:0]               imsic_addr_i = '0, imsic_data_i = '0;
   logic                      imsic_we_i = 1'b0, imsic_claim_i = 1'b0;
   logic [63:0]               imsic_data_o;
   logic                      imsic_exception_o;
   logic [NR_FILES*SRC_W-1:0] imsic_xtopei_o;
   logic                      msi_valid_i = 1'b0, msi_ready_o;
   logic [1:0]                msi_file_i = '0;
   logic [SRC_W-1:0]          msi_id_i = '0;
   logic [NR_FILES-1:0]       irq_o;

   int          checks = 0, errors = 0;
   logic [64:0] sb[$];
   logic [64:0] e, got;

   imsic_regfile #(.NR_SRC(NR_SRC), .NR_VS_FILES(NR_VS_FILES)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .imsic_priv_lvl_i(imsic_priv_lvl_i), .imsic_vgein_i(imsic_vgein_i),
      .imsic_addr_i(imsic_addr_i), .imsic_data_i(imsic_data_i),
      .imsic_we_i(imsic_we_i), .imsic_claim_i(imsic_claim_i),
      .imsic_data_o(imsic_data_o), .imsic_exception_o(imsic_exception_o),
      .imsic_xtopei_o(imsic_xtopei_o),
      .msi_valid_i(msi_valid_i), .msi_ready_o(msi_ready_o),
      .msi_file_i(msi_file_i), .msi_id_i(msi_id_i), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic acc(input logic [1:0] p, input logic [1:0] vg, input logic [63:0] a,
                      input logic [63:0] wd, input logic we, input logic cl, input logic [64:0] exp);
      imsic_priv_lvl_i = p; imsic_vgein_i = vg; imsic_addr_i = a;
      imsic_data_i = wd; imsic_we_i = we; imsic_claim_i = cl;
      sb.push_back(exp);
      @(posedge clk_i); #1;
      imsic_we_i = 1'b0; imsic_claim_i = 1'b0; msi_valid_i = 1'b0;
   endtask

   task automatic msi(input logic [1:0] f, input logic [SRC_W-1:0] id);
      msi_valid_i = 1'b1; msi_file_i = f; msi_id_i = id;
      @(posedge clk_i); #1;
      msi_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk_i); #1;
      checks++;
      if ({imsic_data_o, imsic_exception_o, imsic_xtopei_o, irq_o, msi_ready_o} !== '0) begin
         errors++; $display("FAIL reset_outs got d=%h x=%b t=%h i=%b r=%b exp all 0",
                            imsic_data_o, imsic_exception_o, imsic_xtopei_o, irq_o, msi_ready_o);
      end
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      acc(PM, 0, 64'h80, 0, 0, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL reset_rd got %h exp %h", got, e); end
      checks++;
      if (msi_ready_o !== 1'b1 || irq_o !== 3'b000) begin
         errors++; $display("FAIL reset_rdy got r=%b i=%b exp r=1 i=000", msi_ready_o, irq_o);
      end
   endtask

   task automatic test_s_claim();
      msi(1, 5);
      acc(PS, 0, 64'hC0, 64'h20, 1, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL s_eie_wr got %h exp %h", got, e); end
      acc(PS, 0, 64'h70, 64'h1, 1, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL s_deliv_wr got %h exp %h", got, e); end
      checks++;
      if (imsic_xtopei_o[SRC_W +: SRC_W] !== 6'd5 || irq_o !== 3'b010) begin
         errors++; $display("FAIL s_top got t=%0d i=%b exp t=5 i=010", imsic_xtopei_o[SRC_W +: SRC_W], irq_o);
      end
      acc(PS, 0, 64'h80, 0, 0, 0, {1'b0, 64'h20});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL s_eip_rd got %h exp %h", got, e); end
      acc(PS, 0, 64'h70, 0, 0, 1, {1'b0, 64'h1});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL s_claim got %h exp %h", got, e); end
      checks++;
      if (imsic_xtopei_o[SRC_W +: SRC_W] !== 6'd0 || irq_o !== 3'b000) begin
         errors++; $display("FAIL s_claimed got t=%0d i=%b exp t=0 i=000", imsic_xtopei_o[SRC_W +: SRC_W], irq_o);
      end
      acc(PS, 0, 64'h80, 0, 0, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL s_eip_clr got %h exp %h", got, e); end
   endtask

   task automatic test_threshold();
      logic [63:0] thr_w[5]   = '{64'h4, 64'h3, 64'h0, 64'h145, 64'h0};
      logic [63:0] thr_old[5] = '{64'h0, 64'h4, 64'h3, 64'h0,   64'h5};
      logic [5:0]  top_exp[5] = '{6'd3, 6'd0, 6'd3, 6'd3, 6'd3};
      msi(0, 9);
      msi(0, 3);
      acc(PM, 0, 64'hC0, '1, 1, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL m_eie_wr got %h exp %h", got, e); end
      acc(PM, 0, 64'hC0, 0, 0, 0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL m_eie_bit0 got %h exp %h", got, e); end
      for (int k = 0; k < 5; k++) begin
         acc(PM, 0, 64'h72, thr_w[k], 1, 0, {1'b0, thr_old[k]});
         e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
         if (got !== e) begin errors++; $display("FAIL thr_wr%0d got %h exp %h", k, got, e); end
         checks++;
         if (imsic_xtopei_o[0 +: SRC_W] !== top_exp[k] || irq_o[0] !== 1'b0) begin
            errors++; $display("FAIL thr_top%0d got t=%0d i=%b exp t=%0d i=0",
                               k, imsic_xtopei_o[0 +: SRC_W], irq_o[0], top_exp[k]);
         end
      end
   endtask

   task automatic test_illegal();
      acc(PM, 0, 64'h81, '1, 1, 1, {1'b1, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL ill_odd got %h exp %h", got, e); end
      acc(PM, 0, 64'h71, 64'h1, 1, 0, {1'b1, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL ill_71 got %h exp %h", got, e); end
      acc(2'b00, 0, 64'h70, 64'h1, 1, 1, {1'b1, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL ill_priv00 got %h exp %h", got, e); end
      acc(2'b10, 0, 64'h70, 64'h1, 1, 0, {1'b1, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL ill_priv10 got %h exp %h", got, e); end
      acc(PS, 2, 64'h70, 64'h0, 1, 1, {1'b1, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL ill_vgein got %h exp %h", got, e); end
      acc(PM, 0, 64'h82, '1, 1, 0, {1'b1, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL ill_word1 got %h exp %h", got, e); end
      acc(PM, 0, 64'h170, 64'h1, 1, 0, {1'b1, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL ill_hi got %h exp %h", got, e); end
      acc(PM, 0, 64'h80, 0, 0, 0, {1'b0, 64'h208});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL ill_m_eip got %h exp %h", got, e); end
      acc(PM, 0, 64'h70, 0, 0, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL ill_m_deliv got %h exp %h", got, e); end
      acc(PS, 0, 64'h70, 0, 0, 0, {1'b0, 64'h1});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL ill_s_deliv got %h exp %h", got, e); end
   endtask

   task automatic test_same_cycle();
      acc(PS, 1, 64'hC0, 64'h80, 1, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL vs_eie_wr got %h exp %h", got, e); end
      msi_valid_i = 1'b1; msi_file_i = 2; msi_id_i = 7;
      acc(PS, 1, 64'h80, 64'h0, 1, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL vs_msi_wr got %h exp %h", got, e); end
      acc(PS, 1, 64'h80, 0, 0, 0, {1'b0, 64'h80});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL vs_msi_wins_wr got %h exp %h", got, e); end
      checks++;
      if (imsic_xtopei_o[2*SRC_W +: SRC_W] !== 6'd7) begin
         errors++; $display("FAIL vs_top got %0d exp 7", imsic_xtopei_o[2*SRC_W +: SRC_W]);
      end
      msi_valid_i = 1'b1; msi_file_i = 2; msi_id_i = 7;
      acc(PS, 1, 64'h70, 0, 0, 1, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL vs_claim_msi got %h exp %h", got, e); end
      acc(PS, 1, 64'h80, 0, 0, 0, {1'b0, 64'h80});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL vs_msi_wins_claim got %h exp %h", got, e); end
      acc(PS, 1, 64'h70, 0, 0, 1, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL vs_claim got %h exp %h", got, e); end
      msi(3, 5);
      msi(2, 0);
      acc(PS, 1, 64'h80, 0, 0, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL vs_claimed_drop got %h exp %h", got, e); end
      checks++;
      if (imsic_xtopei_o[2*SRC_W +: SRC_W] !== 6'd0) begin
         errors++; $display("FAIL vs_top_clr got %0d exp 0", imsic_xtopei_o[2*SRC_W +: SRC_W]);
      end
   endtask

   task automatic test_reset_mid();
      acc(PM, 0, 64'h70, 64'h1, 1, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL rm_deliv got %h exp %h", got, e); end
      acc(PM, 0, 64'h80, 0, 0, 0, {1'b0, 64'h208});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL rm_eip got %h exp %h", got, e); end
      checks++;
      if (irq_o !== 3'b001) begin errors++; $display("FAIL rm_irq got %b exp 001", irq_o); end
      imsic_addr_i = 64'hC0; imsic_data_i = 64'h0; imsic_we_i = 1'b1;
      #2 rst_ni = 1'b0;
      #1 checks++;
      if ({imsic_data_o, imsic_exception_o, imsic_xtopei_o, irq_o, msi_ready_o} !== '0) begin
         errors++; $display("FAIL rm_async got d=%h x=%b t=%h i=%b r=%b exp all 0",
                            imsic_data_o, imsic_exception_o, imsic_xtopei_o, irq_o, msi_ready_o);
      end
      imsic_we_i = 1'b0;
      @(posedge clk_i); #3 rst_ni = 1'b1;
      @(posedge clk_i); #1;
      acc(PM, 0, 64'h80, 0, 0, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL rm_m_eip got %h exp %h", got, e); end
      acc(PM, 0, 64'hC0, 0, 0, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL rm_m_eie got %h exp %h", got, e); end
      acc(PM, 0, 64'h70, 0, 0, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL rm_m_deliv got %h exp %h", got, e); end
      acc(PS, 0, 64'hC0, 0, 0, 0, {1'b0, 64'h0});
      e = sb.pop_front(); got = {imsic_exception_o, imsic_data_o}; checks++;
      if (got !== e) begin errors++; $display("FAIL rm_s_eie got %h exp %h", got, e); end
   endtask

   initial begin
      test_reset();
      test_s_claim();
      test_threshold();
      test_illegal();
      test_same_cycle();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
